hnf_txreq_sched: RTL and testbench

//  - HN-F TXREQ scheduler: arbitrates NUM_REQ internal requesters (miss read, victim write, etc.) onto the single CHI TXREQ channel to the SN-F.
//  - Owns the TXREQ L-credit counter and sequences TXREQFLITPEND/TXREQFLITV per CHI link-layer rules.
//  - Downstream of HN-F request processing; drives the TXREQ pins directly.

---
 rtl/hnf_txreq_sched_pkg.sv | 44 ++++
 rtl/hnf_txreq_sched_if.sv | 37 +++
 rtl/hnf_txreq_sched_rr_arbiter.sv | 50 +++++
 rtl/hnf_txreq_sched.sv | 135 +++++++++++++
 tb/tb_hnf_txreq_sched.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/hnf_txreq_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hnf_txreq_sched_pkg
// Purpose : Shared CHI TXREQ definitions for the HN-F TXREQ scheduler:
//           request flit layout, link credit limit, node-ID width and a
//           helper that retargets a flit to a fixed destination node.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package hnf_txreq_sched_pkg;

  // Largest number of L-credits a CHI receiver may hand out on one channel
  localparam int CHI_MAX_LCRD = 15;
  localparam int CHI_NODEID_W = 7;
  localparam int CHI_QOS_W    = 4;
  localparam int CHI_TXNID_W  = 8;
  localparam int CHI_OPCODE_W = 6;
  localparam int CHI_ADDR_W   = 48;

  typedef struct packed {
    logic [CHI_QOS_W-1:0]    QoS;
    logic [CHI_NODEID_W-1:0] TgtID;
    logic [CHI_NODEID_W-1:0] SrcID;
    logic [CHI_TXNID_W-1:0]  TxnID;
    logic [CHI_OPCODE_W-1:0] Opcode;
    logic [2:0]              Size;
    logic [CHI_ADDR_W-1:0]   Addr;
    logic                    NS;
    logic                    AllowRetry;
    logic                    ExpCompAck;
    logic [3:0]              MemAttr;
  } reqflit_t;

  // Every flit leaving the HN-F on TXREQ goes to the single SN-F
  function automatic reqflit_t retarget(input reqflit_t f,
                                        input logic [CHI_NODEID_W-1:0] tgt);
    reqflit_t r;
    r       = f;
    r.TgtID = tgt;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hnf_txreq_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : hnf_txreq_sched_if
// Purpose : Bundles the requester-side handshake and the CHI TXREQ link pins
//           of the HN-F TXREQ scheduler.
// Signals : req_valid/req_flit/req_ready  - requester handshake (NUM_REQ wide)
//           TXREQFLIT/TXREQFLITV/TXREQFLITPEND - link outputs
//           TXREQLCRDV                    - link credit return
// Modports: slave  - the scheduler
//           master - the requesters plus the link receiver
// Rev     : 1.0  initial release
// ============================================================================
interface hnf_txreq_sched_if #(
  parameter int NUM_REQ = 4
) ();
  import hnf_txreq_sched_pkg::*;

  logic     [NUM_REQ-1:0] req_valid;
  reqflit_t [NUM_REQ-1:0] req_flit;
  logic     [NUM_REQ-1:0] req_ready;
  reqflit_t               TXREQFLIT;
  logic                   TXREQFLITV;
  logic                   TXREQFLITPEND;
  logic                   TXREQLCRDV;

  modport slave (
    input  req_valid, req_flit, TXREQLCRDV,
    output req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
  );

  modport master (
    output req_valid, req_flit, TXREQLCRDV,
    input  req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
  );

endinterface
`default_nettype wire

// File: rtl/hnf_txreq_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : hnf_txreq_sched_rr_arbiter
// Purpose : Combinational round-robin picker. Scans i_req starting at i_ptr
//           and wrapping, returns the first set bit as a one-hot grant plus
//           its index.
// Ports   : i_req      N-bit request vector
//           i_ptr      start position of the search
//           o_gnt      one-hot grant (zero when no request)
//           o_gnt_idx  index of the granted bit
//           o_gnt_any  any request granted
// Rev     : 1.0  initial release
// ============================================================================
module hnf_txreq_sched_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_any
);

  // (base + off) mod N, with off < N so one subtraction suffices
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [IDX_W-1:0] w_idx;
      w_idx = wrap_add(i_ptr, k);
      if (!o_gnt_any && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
        o_gnt_any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hnf_txreq_sched.sv
`default_nettype none
// ============================================================================
// Module  : hnf_txreq_sched
// Purpose : HN-F TXREQ scheduler. Arbitrates NUM_REQ internal requesters onto
//           the single CHI TXREQ channel towards the SN-F, owns the TXREQ
//           L-credit counter and sequences TXREQFLITPEND / TXREQFLITV.
// Ports   : clock, reset     clock and synchronous active-high reset
//           bus (slave)      requester handshake + TXREQ link pins
//           lcrd_cnt         L-credits currently held
//           lcrd_overflow    sticky: credit returned while already at max
// Config  : HNF_TXREQ_QOS_ARB_EN  when defined, only requesters carrying the
//           highest QoS compete (round-robin among them); when undefined,
//           pure round-robin and QoS is only forwarded.
// Rev     : 1.0  initial release
// ============================================================================
module hnf_txreq_sched
  import hnf_txreq_sched_pkg::*;
#(
  parameter int                      NUM_REQ     = 4,
  parameter int                      MAX_LCRD    = CHI_MAX_LCRD,
  parameter logic [CHI_NODEID_W-1:0] SNF_NODE_ID = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  hnf_txreq_sched_if.slave              bus,
  output logic [$clog2(MAX_LCRD+1)-1:0] lcrd_cnt,
  output logic                          lcrd_overflow
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LCRD + 1);
  localparam logic [CNT_W-1:0] c_LCRD_MAX = CNT_W'(MAX_LCRD);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_REQ - 1);

  logic             r_pend;
  logic             r_flitv;
  reqflit_t         r_flit;
  logic [CNT_W-1:0] r_lcrd_cnt;
  logic             r_overflow;
  logic [IDX_W-1:0] r_ptr;

  logic [NUM_REQ-1:0] w_arb_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_any;
  logic               w_grant;
  logic               w_cnt_max;

  // ---------------------------------------------------------------------------
  // Arbitration candidates
  // ---------------------------------------------------------------------------
`ifdef HNF_TXREQ_QOS_ARB_EN
  logic [CHI_QOS_W-1:0] w_max_qos;

  always_comb begin
    w_max_qos = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && (bus.req_flit[i].QoS > w_max_qos))
        w_max_qos = bus.req_flit[i].QoS;
    end
  end

  // Only the highest-QoS valid requesters go to the round-robin stage
  always_comb begin
    w_arb_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_arb_req[i] = bus.req_valid[i] && (bus.req_flit[i].QoS == w_max_qos);
    end
  end
`else
  assign w_arb_req = bus.req_valid;
`endif

  hnf_txreq_sched_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req     (w_arb_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  // PEND must have been visible for a cycle before FLITV can follow, hence
  // the registered pend term. Only credits already held count: a credit
  // returning this cycle becomes usable next cycle.
  assign w_grant   = r_pend && w_gnt_any && (r_lcrd_cnt != '0);
  assign w_cnt_max = (r_lcrd_cnt == c_LCRD_MAX);

  assign bus.req_ready = w_grant ? w_gnt : '0;

  // ---------------------------------------------------------------------------
  // Pend, flit output, credit counter and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend     <= 1'b0;
      r_flitv    <= 1'b0;
      r_flit     <= '0;
      r_lcrd_cnt <= '0;
      r_overflow <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_pend  <= |bus.req_valid;
      r_flitv <= w_grant;

      if (w_grant) begin
        r_flit <= retarget(bus.req_flit[w_gnt_idx], SNF_NODE_ID);
        r_ptr  <= (w_gnt_idx == c_IDX_LAST) ? '0 : w_gnt_idx + 1'b1;
      end

      // Credit return and consumption in the same cycle cancel out
      unique case ({bus.TXREQLCRDV, w_grant})
        2'b10: begin
          if (!w_cnt_max) r_lcrd_cnt <= r_lcrd_cnt + 1'b1;
        end
        2'b01: r_lcrd_cnt <= r_lcrd_cnt - 1'b1;
        default: r_lcrd_cnt <= r_lcrd_cnt;
      endcase

      // A receiver returning a credit while we already hold the maximum has
      // broken the link protocol; remember it until the next reset.
      if (bus.TXREQLCRDV && w_cnt_max) r_overflow <= 1'b1;
    end
  end

  assign bus.TXREQFLIT     = r_flit;
  assign bus.TXREQFLITV    = r_flitv;
  assign bus.TXREQFLITPEND = r_pend;
  assign lcrd_cnt          = r_lcrd_cnt;
  assign lcrd_overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hnf_txreq_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_hnf_txreq_sched
// Purpose : Self-checking bench for hnf_txreq_sched (NUM_REQ=4, MAX_LCRD=15).
//           A cycle table covers pend, credit gating and round-robin; short
//           hand-written sequences cover saturation, full-rate issue, reset
//           mid-operation and QoS ordering.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hnf_txreq_sched;
  import hnf_txreq_sched_pkg::*;

  localparam int         N   = 4;
  localparam logic [6:0] SNF = 7'h2A;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] lcrd_cnt;
  logic       lcrd_overflow;

  int total = 0;
  int bad   = 0;

  hnf_txreq_sched_if #(.NUM_REQ(N)) bus ();

  hnf_txreq_sched #(
    .NUM_REQ     (N),
    .MAX_LCRD    (15),
    .SNF_NODE_ID (SNF)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .lcrd_cnt      (lcrd_cnt),
    .lcrd_overflow (lcrd_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] valid;
    logic       lcrdv;
    logic [3:0] rdy;    // req_ready expected in the same cycle
    logic       pend;   // after the edge
    logic       flitv;  // after the edge
    int         src;    // requester whose flit should be on TXREQFLIT
    logic [3:0] cnt;    // after the edge
  } vec_t;

  vec_t tbl [20];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_flits(input logic [15:0] qos);
    for (int i = 0; i < N; i++) begin
      reqflit_t f;
      f            = '0;
      f.QoS        = qos[4*i +: 4];
      f.TgtID      = 7'h7F;
      f.SrcID      = 7'h03;
      f.TxnID      = 8'h10 + 8'(i);
      f.Opcode     = 6'h04;
      f.Size       = 3'd6;
      f.Addr       = 48'h1000 * 48'(i + 1);
      bus.req_flit[i] = f;
    end
  endtask

  task automatic chk_flit(input string nm, input int src, input logic [3:0] qos);
    chk({nm, "_flitv"}, 64'(bus.TXREQFLITV), 64'd1);
    chk({nm, "_tgtid"}, 64'(bus.TXREQFLIT.TgtID), 64'(SNF));
    chk({nm, "_txnid"}, 64'(bus.TXREQFLIT.TxnID), 64'(8'h10 + 8'(src)));
    chk({nm, "_addr"},  64'(bus.TXREQFLIT.Addr), 64'(48'h1000 * 48'(src + 1)));
    chk({nm, "_qos"},   64'(bus.TXREQFLIT.QoS), 64'(qos));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid  = '0;
    bus.TXREQLCRDV = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic add_credits(input int n);
    bus.req_valid  = '0;
    bus.TXREQLCRDV = 1'b1;
    repeat (n) tick();
    bus.TXREQLCRDV = 1'b0;
  endtask

  initial begin
    int         order [3];
    logic [3:0] qv    [4];
    logic [3:0] remaining;

    bus.req_valid  = '0;
    bus.TXREQLCRDV = 1'b0;
    load_flits(16'h0000);

    //            valid    lcrdv rdy      pend  flitv src cnt
    tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 4'd0};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 4'd0};
    tbl[2]  = '{4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'd1};  // cnt 0 + LCRDV: no grant
    tbl[3]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 0, 4'd1};  // grant + LCRDV: cnt held
    tbl[4]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 0, 4'd0};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 4'd0};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 4'd1};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 4'd2};
    tbl[8]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 4'd2};  // pend not yet seen
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 0, 4'd1};
    tbl[10] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 0, 4'd0};
    tbl[11] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 4'd0};  // out of credits
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 4'd1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 4'd2};
    tbl[14] = '{4'b1010, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 4'd3};
    tbl[15] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 1'b1, 1, 4'd2};  // ptr=1
    tbl[16] = '{4'b1010, 1'b0, 4'b1000, 1'b1, 1'b1, 3, 4'd1};  // ptr=2
    tbl[17] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 1, 4'd1};  // ptr=0, wraps
    tbl[18] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 2, 4'd0};
    tbl[19] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 4'd0};

    // ---------------- reset state ----------------
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_pend",  64'(bus.TXREQFLITPEND), 64'd0);
    chk("rst_flitv", 64'(bus.TXREQFLITV), 64'd0);
    chk("rst_flit0", 64'(bus.TXREQFLIT == '0), 64'd1);
    chk("rst_cnt",   64'(lcrd_cnt), 64'd0);
    chk("rst_ovf",   64'(lcrd_overflow), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);

    // ---------------- cycle table ----------------
    for (int i = 0; i < 20; i++) begin
      bus.req_valid  = tbl[i].valid;
      bus.TXREQLCRDV = tbl[i].lcrdv;
      #1;
      chk($sformatf("t%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].rdy));
      tick();
      chk($sformatf("t%0d_pend", i),  64'(bus.TXREQFLITPEND), 64'(tbl[i].pend));
      chk($sformatf("t%0d_flitv", i), 64'(bus.TXREQFLITV), 64'(tbl[i].flitv));
      chk($sformatf("t%0d_cnt", i),   64'(lcrd_cnt), 64'(tbl[i].cnt));
      chk($sformatf("t%0d_ovf", i),   64'(lcrd_overflow), 64'd0);
      if (tbl[i].flitv)
        chk_flit($sformatf("t%0d", i), tbl[i].src, 4'd0);
    end
    bus.req_valid  = '0;
    bus.TXREQLCRDV = 1'b0;

    // ---------------- saturation and overflow ----------------
    do_reset();
    add_credits(15);
    chk("sat_cnt15", 64'(lcrd_cnt), 64'd15);
    chk("sat_ovf0",  64'(lcrd_overflow), 64'd0);
    bus.TXREQLCRDV = 1'b1;
    tick();
    bus.TXREQLCRDV = 1'b0;
    chk("sat_cnt_hold", 64'(lcrd_cnt), 64'd15);
    chk("sat_ovf1",     64'(lcrd_overflow), 64'd1);

    // ---------------- full-rate round-robin ----------------
    bus.req_valid = 4'b1111;
    tick();
    chk("rr_pend", 64'(bus.TXREQFLITPEND), 64'd1);
    chk("rr_noflit", 64'(bus.TXREQFLITV), 64'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk_flit($sformatf("rr%0d", k), k % 4, 4'd0);
      chk($sformatf("rr%0d_cnt", k), 64'(lcrd_cnt), 64'(15 - (k + 1)));
    end
    chk("rr_ovf_sticky", 64'(lcrd_overflow), 64'd1);

    // ---------------- reset while issuing ----------------
    reset = 1'b1;
    tick();
    chk("mid_rst_flitv", 64'(bus.TXREQFLITV), 64'd0);
    chk("mid_rst_cnt",   64'(lcrd_cnt), 64'd0);
    chk("mid_rst_ovf",   64'(lcrd_overflow), 64'd0);
    chk("mid_rst_pend",  64'(bus.TXREQFLITPEND), 64'd0);
    reset = 1'b0;
    bus.req_valid = '0;

    // ---------------- QoS ordering ----------------
    do_reset();
    qv[0] = 4'd2; qv[1] = 4'd0; qv[2] = 4'd9; qv[3] = 4'd9;
    load_flits({qv[3], qv[2], qv[1], qv[0]});
    add_credits(3);
`ifdef HNF_TXREQ_QOS_ARB_EN
    order = '{2, 3, 0};
`else
    order = '{0, 2, 3};
`endif
    remaining     = 4'b1101;
    bus.req_valid = remaining;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = remaining;
      #1;
      chk($sformatf("qos%0d_ready", k), 64'(bus.req_ready), 64'(4'b0001 << order[k]));
      tick();
      chk_flit($sformatf("qos%0d", k), order[k], qv[order[k]]);
      remaining = remaining & ~(4'b0001 << order[k]);
    end
    bus.req_valid = remaining;
    chk("qos_cnt_end", 64'(lcrd_cnt), 64'd0);
    tick();
    chk("qos_idle_flitv", 64'(bus.TXREQFLITV), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
